// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths, the op record and the responder state encoding
// for the I2C environment.
package i2c_pkg;
    localparam int I2C_SLAVE_ADDR_SIZE = 7;
    localparam int I2C_BYTE_SIZE = 8;

    typedef struct packed {
        logic [I2C_SLAVE_ADDR_SIZE-1:0] addr;
        logic                           rw;
    } i2c_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_resp_state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: two-flop synchronizers plus a history stage for SCL/SDA,
// producing SCL edge pulses and START/STOP events on the synchronized lines.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);
    // [1:0] synchronizer, [2] history; reset to the idle-high bus level
    logic [2:0] scl_q, sda_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    assign sda_o      = sda_q[1];
    assign scl_rise_o = scl_q[1] & ~scl_q[2];
    assign scl_fall_o = ~scl_q[1] & scl_q[2];
    assign start_o    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    assign stop_o     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
endmodule

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target that ACKs SLAVE_ADDR, hands write bytes to the
// fabric and fetches read bytes on demand, driving SDA open-drain.
module i2c_slave_responder #(
    parameter int I2C_SLAVE_ADDR_SIZE = i2c_pkg::I2C_SLAVE_ADDR_SIZE,
    parameter int I2C_BYTE_SIZE = i2c_pkg::I2C_BYTE_SIZE,
    parameter logic [I2C_SLAVE_ADDR_SIZE-1:0] SLAVE_ADDR = 7'h22
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           scl_i,
    input  logic                           sda_i,
    output logic                           sda_drive_low,
    output logic                           op_valid,
    output logic [I2C_SLAVE_ADDR_SIZE-1:0] op_addr,
    output logic                           op_rw,
    output logic                           wr_valid,
    output logic [I2C_BYTE_SIZE-1:0]       wr_data,
    output logic                           rd_req,
    input  logic [I2C_BYTE_SIZE-1:0]       rd_data,
    output logic                           stop_seen,
    output logic                           busy
);
    import i2c_pkg::*;

    localparam int BW = I2C_BYTE_SIZE;
    localparam logic [3:0] LAST_BIT = 4'(BW - 1);
    localparam logic [3:0] ALL_BITS = 4'(BW);

    logic sda_s, scl_rise, scl_fall, start_ev, stop_ev, ack_rd;
    i2c_resp_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [BW-1:0] shift_q, shift_d, byte_in, wr_data_q, wr_data_d;
    i2c_op_t op_q, op_d;
    logic sda_q, sda_d, op_valid_q, op_valid_d, wr_valid_q, wr_valid_d;
    logic rd_req_q, rd_req_d, stop_q, stop_d, busy_q, busy_d, load_q, load_d;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_o     (sda_s),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start_ev),
        .stop_o    (stop_ev)
    );

    assign byte_in = {shift_q[BW-2:0], sda_s};
    assign ack_rd  = (state_q == ST_ADDR_ACK) && op_q.rw;

    // ACK phases use cnt_q as a sub-phase: 0 = before the driving fall, 1 = ACK held
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = load_q ? rd_data : shift_q;
        op_d       = op_q;
        wr_data_d  = wr_data_q;
        sda_d      = sda_q;
        busy_d     = busy_q;
        load_d     = rd_req_q;
        op_valid_d = 1'b0;
        wr_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        stop_d     = 1'b0;
        if (start_ev || stop_ev) begin
            state_d = start_ev ? ST_ADDR : ST_IDLE;
            stop_d  = stop_ev;
            sda_d   = 1'b0;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d = '0;
                        if (byte_in[BW-1 -: I2C_SLAVE_ADDR_SIZE] == SLAVE_ADDR) begin
                            state_d    = ST_ADDR_ACK;
                            op_d       = i2c_op_t'(byte_in);
                            op_valid_d = 1'b1;
                            busy_d     = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (cnt_q == '0) begin
                        sda_d      = 1'b1;
                        cnt_d      = 4'd1;
                        rd_req_d   = ack_rd;
                        wr_valid_d = state_q == ST_WR_ACK;
                        wr_data_d  = (state_q == ST_WR_ACK) ? shift_q : wr_data_q;
                    end else begin
                        state_d = ack_rd ? ST_RD_BYTE : ST_WR_BYTE;
                        sda_d   = ack_rd ? ~shift_q[BW-1] : 1'b0;
                        shift_d = ack_rd ? shift_q << 1 : shift_q;
                        cnt_d   = ack_rd ? 4'd1 : 4'd0;
                    end
                end
                ST_WR_BYTE: if (scl_rise) begin
                    shift_d = byte_in;
                    cnt_d   = (cnt_q == LAST_BIT) ? 4'd0 : cnt_q + 4'd1;
                    state_d = (cnt_q == LAST_BIT) ? ST_WR_ACK : ST_WR_BYTE;
                end
                ST_RD_BYTE: if (scl_fall) begin
                    if (cnt_q == ALL_BITS) begin
                        state_d = ST_RD_ACK;
                        sda_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        sda_d   = ~shift_q[BW-1];
                        shift_d = shift_q << 1;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                ST_RD_ACK: if (scl_rise) begin
                    state_d  = sda_s ? ST_IGNORE : ST_RD_BYTE;
                    rd_req_d = ~sda_s;
                    busy_d   = ~sda_s;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            op_q       <= '0;
            wr_data_q  <= '0;
            sda_q      <= 1'b0;
            op_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            op_q       <= op_d;
            wr_data_q  <= wr_data_d;
            sda_q      <= sda_d;
            op_valid_q <= op_valid_d;
            wr_valid_q <= wr_valid_d;
            rd_req_q   <= rd_req_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
            load_q     <= load_d;
        end
    end

    assign sda_drive_low = sda_q;
    assign op_valid      = op_valid_q;
    assign op_addr       = op_q.addr;
    assign op_rw         = op_q.rw;
    assign wr_valid      = wr_valid_q;
    assign wr_data       = wr_data_q;
    assign rd_req        = rd_req_q;
    assign stop_seen     = stop_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: bus-level master driving directed transactions; expected
// events are queued by the stimulus and popped by independent monitors.
module tb_i2c_slave_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic sda_m = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic sda_drive_low, op_valid, op_rw, wr_valid, rd_req, stop_seen, busy;
    logic [6:0] op_addr;
    logic [7:0] wr_data;
    logic sda_line;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_test = 0;
    int rd_exp_total = 0;
    int rd_seen = 0;

    logic       exp_sda[$];
    logic [7:0] exp_op[$];
    logic [7:0] exp_wr[$];
    int         exp_stop[$];
    logic [7:0] rd_q[$];

    assign sda_line = sda_m & ~sda_drive_low;

    always #5 clk = ~clk;

    i2c_slave_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scl_i        (scl),
        .sda_i        (sda_line),
        .sda_drive_low(sda_drive_low),
        .op_valid     (op_valid),
        .op_addr      (op_addr),
        .op_rw        (op_rw),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .stop_seen    (stop_seen),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexp(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got unexpected pulse, want none (t=%0t)", name, $time);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one SCL clock starting and ending with SCL just fallen
    task automatic pulse(input logic b, input logic drv);
        wait_clk(4);
        sda_m = b;
        wait_clk(4);
        exp_sda.push_back(drv);
        scl = 1'b1;
        wait_clk(8);
        scl = 1'b0;
    endtask

    task automatic start_c();
        if (!scl) begin
            wait_clk(4);
            sda_m = 1'b1;
            wait_clk(4);
            exp_sda.push_back(1'b0);
            scl = 1'b1;
        end
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        scl = 1'b0;
    endtask

    task automatic stop_c(input int tag);
        exp_stop.push_back(tag);
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        exp_sda.push_back(1'b0);
        scl = 1'b1;
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(8);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) pulse(b[i], 1'b0);
        pulse(1'b1, ack);
    endtask

    task automatic rd_byte(input logic [7:0] b, input logic mack);
        for (int i = 7; i >= 0; i--) pulse(1'b1, ~b[i]);
        pulse(~mack, 1'b0);
    endtask

    task automatic addr_phase(input logic [6:0] a, input logic rw, input logic ack);
        if (ack) exp_op.push_back({a, rw});
        wr_byte({a, rw}, ack);
    endtask

    task automatic wr_data_byte(input logic [7:0] b);
        exp_wr.push_back(b);
        wr_byte(b, 1'b1);
    endtask

    task automatic rd_push(input logic [7:0] b);
        rd_q.push_back(b);
        rd_exp_total++;
    endtask

    // SDA scoreboard: the slave's drive level at every SCL rise
    initial forever begin
        @(posedge scl);
        if (exp_sda.size() == 0) unexp("sda_slot");
        else check("sda_drive", sda_drive_low, exp_sda.pop_front());
    end

    // fabric-side monitor and read-data model
    initial forever begin
        @(negedge clk);
        if (op_valid) begin
            if (exp_op.size() == 0) unexp("op_valid");
            else check("op", {op_addr, op_rw}, exp_op.pop_front());
        end
        if (wr_valid) begin
            if (exp_wr.size() == 0) unexp("wr_valid");
            else check("wr_data", wr_data, exp_wr.pop_front());
        end
        if (rd_req) begin
            rd_seen++;
            if (rd_q.size() == 0) unexp("rd_req");
            else rd_data = rd_q.pop_front();
        end
        if (stop_seen) begin
            if (exp_stop.size() == 0) unexp("stop_seen");
            else check("stop_tag", cur_test, exp_stop.pop_front());
        end
    end

    initial begin
        wait_clk(3);
        check("rst_sda", sda_drive_low, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_stop", stop_seen, 0);
        check("rst_busy", busy, 0);
        check("rst_op_addr", op_addr, 0);
        check("rst_op_rw", op_rw, 0);
        check("rst_wr_data", wr_data, 0);
        rst_n = 1'b1;
        wait_clk(4);

        cur_test = 1;
        start_c();
        addr_phase(7'h22, 1'b0, 1'b1);
        check("busy_after_match", busy, 1);
        wr_data_byte(8'hA5);
        wr_data_byte(8'h3C);
        stop_c(1);
        check("busy_after_stop", busy, 0);
        check("wr_data_held", wr_data, 8'h3C);

        cur_test = 2;
        rd_push(8'h5A);
        rd_push(8'hF0);
        start_c();
        addr_phase(7'h22, 1'b1, 1'b1);
        rd_byte(8'h5A, 1'b1);
        rd_byte(8'hF0, 1'b0);
        check("busy_after_nack", busy, 0);
        stop_c(2);

        cur_test = 3;
        start_c();
        addr_phase(7'h23, 1'b0, 1'b0);
        check("busy_no_match", busy, 0);
        start_c();
        addr_phase(7'h22, 1'b0, 1'b1);
        wr_data_byte(8'h77);
        stop_c(3);

        cur_test = 4;
        start_c();
        addr_phase(7'h22, 1'b0, 1'b1);
        wr_data_byte(8'h11);
        rd_push(8'h96);
        start_c();
        addr_phase(7'h22, 1'b1, 1'b1);
        rd_byte(8'h96, 1'b0);
        stop_c(4);

        cur_test = 5;
        rd_push(8'h3F);
        start_c();
        addr_phase(7'h22, 1'b1, 1'b1);
        wait_clk(6);
        check("rd_bit7_driven", sda_drive_low, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_release", sda_drive_low, 0);
        wait_clk(2);
        rst_n = 1'b1;
        repeat (3) pulse(1'b1, 1'b0);
        check("busy_after_reset", busy, 0);
        start_c();
        addr_phase(7'h22, 1'b0, 1'b1);
        wr_data_byte(8'hC3);
        stop_c(5);

        cur_test = 6;
        start_c();
        addr_phase(7'h22, 1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        start_c();
        addr_phase(7'h22, 1'b0, 1'b1);
        wr_data_byte(8'h5E);
        stop_c(6);

        wait_clk(20);
        check("rd_req_count", rd_seen, rd_exp_total);
        check("sda_slots_left", exp_sda.size(), 0);
        check("op_left", exp_op.size(), 0);
        check("wr_left", exp_wr.size(), 0);
        check("stop_left", exp_stop.size(), 0);
        check("rd_left", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
